dmem_arbiter: RTL

//  Shares the single-port data RAM between the processor's dmem port and one peripheral

---
 rtl/dmem_arb_pkg.sv | 13 +
 rtl/arb_wait_counter.sv | 32 +++
 rtl/dmem_arbiter.sv | 90 +++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared constants for the data-RAM arbiter: owner encoding of the read-return
// path and the width helper for the anti-starvation counter.
package dmem_arb_pkg;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_PER = 1'b1;

  // Bits needed to count 0..max_wait inclusive.
  function automatic int cnt_width(input int max_wait);
    return $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/arb_wait_counter.sv
// Counts cycles a peripheral request has been blocked by the CPU; saturates at
// MAX_WAIT and flags it so the arbiter can force a peripheral grant.
module arb_wait_counter
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = cnt_width(MAX_WAIT)
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic at_max
);

  localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != MAX_VAL)) begin
      count <= count + 1'b1;
    end
  end

  assign at_max = (count == MAX_VAL);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the CPU dmem port (fixed priority)
// and one peripheral req/ack master, with a forced peripheral grant after MAX_WAIT blocked cycles.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wren,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic [DATA_W-1:0] cpu_q,
  output logic              cpu_stall,
  input  logic              per_req,
  input  logic              per_we,
  input  logic [ADDR_W-1:0] per_addr,
  input  logic [DATA_W-1:0] per_wdata,
  output logic              per_ack,
  output logic              per_rvalid,
  output logic [DATA_W-1:0] per_rdata,
  output logic              ram_wEn,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dataIn,
  input  logic [DATA_W-1:0] ram_dataOut
);

  // Handshake: per_req is held with stable per_* until the single-cycle per_ack;
  // the CPU sees cpu_stall and must re-present the same access the next cycle.

  logic              active;
  logic              at_max;
  logic              force_gnt;
  logic              gnt_per;
  logic              gnt_cpu;
  logic              owner_q;
  logic              rd_pend_q;
  logic [DATA_W-1:0] cpu_hold_q;
  logic [DATA_W-1:0] per_hold_q;

  // While reset is high nothing is granted, so no pulse or RAM write escapes.
  assign active    = ~reset;
  assign force_gnt = per_req & at_max;
  assign gnt_per   = active & per_req & (~cpu_req | force_gnt);
  assign gnt_cpu   = active & cpu_req & ~gnt_per;

  assign cpu_stall = cpu_req & gnt_per;
  assign per_ack   = gnt_per;

  assign ram_wEn    = gnt_per ? per_we    : (gnt_cpu & cpu_wren);
  assign ram_addr   = gnt_per ? per_addr  : cpu_addr;
  assign ram_dataIn = gnt_per ? per_wdata : cpu_data;

  arb_wait_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (gnt_per | ~per_req),
    .inc    (per_req & cpu_req & ~force_gnt),
    .at_max (at_max)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner_q    <= OWNER_CPU;
      rd_pend_q  <= 1'b0;
      cpu_hold_q <= '0;
      per_hold_q <= '0;
    end else begin
      owner_q   <= gnt_per ? OWNER_PER : OWNER_CPU;
      rd_pend_q <= gnt_per & ~per_we;
      if (rd_pend_q) begin
        per_hold_q <= ram_dataOut;
      end
      if (owner_q == OWNER_CPU) begin
        cpu_hold_q <= ram_dataOut;
      end
    end
  end

  // RAM data passes straight through in the return cycle and is held afterwards.
  assign per_rvalid = rd_pend_q;
  assign per_rdata  = rd_pend_q ? ram_dataOut : per_hold_q;
  assign cpu_q      = ((owner_q == OWNER_CPU) && active) ? ram_dataOut : cpu_hold_q;

endmodule
